tic_tac_toe: RTL and testbench

Two-player 3x3 tic-tac-toe controller for a button/LED board. Nine cell buttons (a..i, row-major) place the current player's mark. A computer-move button lets the machine play Player 2's move. The block drives a 2-bit LED code per cell plus turn, win and grid-full indicators, and sits directly between debounced board buttons and the LED drivers.

---
 rtl/tic_tac_toe.sv | 169 ++++++++++++++++
 tb/tb_tic_tac_toe.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/tic_tac_toe.sv
// Two-player 3x3 tic-tac-toe controller: button edge detection, move placement,
// a rule-based computer opponent for Player 2, and combinational LED/flag decode.
module tic_tac_toe (
  input  logic       clk,
  input  logic       reset,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  input  logic       h,
  input  logic       i,
  input  logic       comp_button,
  output logic       p1_turn,
  output logic       p2_turn,
  output logic       p1_win,
  output logic       p2_win,
  output logic       grid_full,
  output logic [1:0] a_led,
  output logic [1:0] b_led,
  output logic [1:0] c_led,
  output logic [1:0] d_led,
  output logic [1:0] e_led,
  output logic [1:0] f_led,
  output logic [1:0] g_led,
  output logic [1:0] h_led,
  output logic [1:0] i_led
);

  localparam int unsigned NCELL = 9;
  localparam int unsigned NLINE = 8;
  localparam int unsigned IDXW  = 4;
  localparam logic [1:0]  EMPTY = 2'b00;
  localparam logic [1:0]  MARK1 = 2'b01;
  localparam logic [1:0]  MARK2 = 2'b10;

  // Cell indices 0..8 map to a..i; line order sets tie-break priority.
  localparam int unsigned LINES [NLINE][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };
  localparam int unsigned FALLBACK [NCELL] = '{4, 0, 2, 6, 8, 1, 3, 5, 7};

  typedef enum logic {TURN_P1 = 1'b0, TURN_P2 = 1'b1} turn_e;

  turn_e            turn_q, turn_d;
  logic [1:0]       cell_q [NCELL];
  logic [1:0]       cell_d [NCELL];
  logic [NCELL-1:0] btn;
  logic [NCELL-1:0] btn_prev_q, btn_prev_d;
  logic             comp_prev_q, comp_prev_d;
  logic [NCELL-1:0] press;
  logic             comp_press;
  logic             any_press;
  logic [IDXW-1:0]  sel_idx;
  logic             comp_found;
  logic [IDXW-1:0]  comp_idx;
  logic [1:0]       want;
  logic             game_over;

  assign btn        = {i, h, g, f, e, d, c, b, a};
  assign press      = btn & ~btn_prev_q;
  assign comp_press = comp_button & ~comp_prev_q;

  // Win and full-board detection.
  always_comb begin
    p1_win    = 1'b0;
    p2_win    = 1'b0;
    grid_full = 1'b1;
    for (int unsigned l = 0; l < NLINE; l++) begin
      if (cell_q[LINES[l][0]] == MARK1 && cell_q[LINES[l][1]] == MARK1 &&
          cell_q[LINES[l][2]] == MARK1) p1_win = 1'b1;
      if (cell_q[LINES[l][0]] == MARK2 && cell_q[LINES[l][1]] == MARK2 &&
          cell_q[LINES[l][2]] == MARK2) p2_win = 1'b1;
    end
    for (int unsigned n = 0; n < NCELL; n++) begin
      if (cell_q[n] == EMPTY) grid_full = 1'b0;
    end
  end

  assign game_over = p1_win | p2_win | grid_full;
  assign p1_turn   = ~game_over & (turn_q == TURN_P1);
  assign p2_turn   = ~game_over & (turn_q == TURN_P2);

  // Lowest-lettered pressed cell wins.
  always_comb begin
    any_press = 1'b0;
    sel_idx   = '0;
    for (int unsigned n = 0; n < NCELL; n++) begin
      if (!any_press && press[n]) begin
        any_press = 1'b1;
        sel_idx   = IDXW'(n);
      end
    end
  end

  // Computer move: complete own line, then block, then centre/corner/edge.
  always_comb begin
    comp_found = 1'b0;
    comp_idx   = '0;
    want       = MARK2;
    for (int unsigned r = 0; r < 2; r++) begin
      want = (r == 0) ? MARK2 : MARK1;
      for (int unsigned l = 0; l < NLINE; l++) begin
        for (int unsigned k = 0; k < 3; k++) begin
          if (!comp_found && cell_q[LINES[l][k]] == EMPTY &&
              cell_q[LINES[l][(k + 1) % 3]] == want &&
              cell_q[LINES[l][(k + 2) % 3]] == want) begin
            comp_found = 1'b1;
            comp_idx   = IDXW'(LINES[l][k]);
          end
        end
      end
    end
    for (int unsigned n = 0; n < NCELL; n++) begin
      if (!comp_found && cell_q[FALLBACK[n]] == EMPTY) begin
        comp_found = 1'b1;
        comp_idx   = IDXW'(FALLBACK[n]);
      end
    end
  end

  // Next-state: a cell press always pre-empts the computer button.
  always_comb begin
    cell_d      = cell_q;
    turn_d      = turn_q;
    btn_prev_d  = btn;
    comp_prev_d = comp_button;
    if (!game_over) begin
      if (any_press) begin
        if (cell_q[sel_idx] == EMPTY) begin
          cell_d[sel_idx] = (turn_q == TURN_P1) ? MARK1 : MARK2;
          turn_d          = (turn_q == TURN_P1) ? TURN_P2 : TURN_P1;
        end
      end else if (comp_press && turn_q == TURN_P2 && comp_found) begin
        cell_d[comp_idx] = MARK2;
        turn_d           = TURN_P1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned n = 0; n < NCELL; n++) cell_q[n] <= EMPTY;
      turn_q      <= TURN_P1;
      btn_prev_q  <= '0;
      comp_prev_q <= 1'b0;
    end else begin
      cell_q      <= cell_d;
      turn_q      <= turn_d;
      btn_prev_q  <= btn_prev_d;
      comp_prev_q <= comp_prev_d;
    end
  end

  assign a_led = cell_q[0];
  assign b_led = cell_q[1];
  assign c_led = cell_q[2];
  assign d_led = cell_q[3];
  assign e_led = cell_q[4];
  assign f_led = cell_q[5];
  assign g_led = cell_q[6];
  assign h_led = cell_q[7];
  assign i_led = cell_q[8];

endmodule

// File: tb/tb_tic_tac_toe.sv
// Self-checking bench for tic_tac_toe: a table of button steps with expected
// boards and flags, queued into a scoreboard, plus an async mid-game reset sequence.
module tb_tic_tac_toe;

  logic       clk, reset;
  logic       a, b, c, d, e, f, g, h, i, comp_button;
  logic       p1_turn, p2_turn, p1_win, p2_win, grid_full;
  logic [1:0] a_led, b_led, c_led, d_led, e_led, f_led, g_led, h_led, i_led;

  tic_tac_toe dut (
    .clk(clk), .reset(reset),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h), .i(i),
    .comp_button(comp_button),
    .p1_turn(p1_turn), .p2_turn(p2_turn), .p1_win(p1_win), .p2_win(p2_win),
    .grid_full(grid_full),
    .a_led(a_led), .b_led(b_led), .c_led(c_led), .d_led(d_led), .e_led(e_led),
    .f_led(f_led), .g_led(g_led), .h_led(h_led), .i_led(i_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [8:0] NONE = 9'h000;
  localparam logic [8:0] BA = 9'h001, BB = 9'h002, BC = 9'h004, BD = 9'h008, BE = 9'h010;
  localparam logic [8:0] BF = 9'h020, BG = 9'h040, BH = 9'h080, BI = 9'h100;
  // Flag order: {p1_turn, p2_turn, p1_win, p2_win, grid_full}
  localparam logic [4:0] P1T = 5'b10000, P2T = 5'b01000, P1W = 5'b00100;
  localparam logic [4:0] P2W = 5'b00010, FULL = 5'b00001;

  typedef struct {
    logic        rst_before;
    logic [8:0]  btn;
    logic        comp;
    int          hold;
    logic [17:0] leds;
    logic [4:0]  flg;
    string       name;
  } step_t;

  typedef struct {
    logic [17:0] leds;
    logic [4:0]  flg;
    string       name;
  } exp_t;

  step_t tbl[$];
  exp_t  sb[$];
  int    errors = 0;
  int    checks = 0;

  logic [17:0] leds_now;
  logic [4:0]  flags_now;
  assign leds_now  = {i_led, h_led, g_led, f_led, e_led, d_led, c_led, b_led, a_led};
  assign flags_now = {p1_turn, p2_turn, p1_win, p2_win, grid_full};

  // Board in row-major order a..i, 0 empty / 1 Player 1 / 2 Player 2.
  function automatic logic [17:0] brd(input int unsigned ca, cb, cc, cd, ce, cf, cg, ch, ci);
    return {2'(ci), 2'(ch), 2'(cg), 2'(cf), 2'(ce), 2'(cd), 2'(cc), 2'(cb), 2'(ca)};
  endfunction

  task automatic add(input logic r, input logic [8:0] bt, input logic cb, input int hold,
                     input logic [17:0] l, input logic [4:0] fl, input string n);
    step_t s;
    s.rst_before = r; s.btn = bt; s.comp = cb; s.hold = hold;
    s.leds = l; s.flg = fl; s.name = n;
    tbl.push_back(s);
  endtask

  task automatic drive(input logic [8:0] bt, input logic cb);
    {i, h, g, f, e, d, c, b, a} = bt;
    comp_button = cb;
  endtask

  task automatic expect_state(input logic [17:0] l, input logic [4:0] fl, input string n);
    exp_t x;
    x.leds = l; x.flg = fl; x.name = n;
    sb.push_back(x);
  endtask

  task automatic check_now();
    exp_t x;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: no expected entry queued");
      return;
    end
    x = sb.pop_front();
    if (leds_now !== x.leds) begin
      errors++;
      $display("FAIL %s leds: got %05h want %05h", x.name, leds_now, x.leds);
    end
    checks++;
    if (flags_now !== x.flg) begin
      errors++;
      $display("FAIL %s flags(p1t,p2t,p1w,p2w,full): got %05b want %05b", x.name, flags_now, x.flg);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    drive(NONE, 1'b0);

    // Game A: Player 1 wins the top row; board freezes afterwards.
    add(1'b0, NONE, 1'b0, 1, brd(0,0,0, 0,0,0, 0,0,0), P1T, "reset_A");
    add(1'b0, BA,   1'b0, 5, brd(1,0,0, 0,0,0, 0,0,0), P2T, "a_held5");
    add(1'b0, BA,   1'b0, 1, brd(1,0,0, 0,0,0, 0,0,0), P2T, "a_again");
    add(1'b0, BD,   1'b0, 1, brd(1,0,0, 2,0,0, 0,0,0), P1T, "d");
    add(1'b0, BB,   1'b0, 1, brd(1,1,0, 2,0,0, 0,0,0), P2T, "b");
    add(1'b0, BE,   1'b0, 1, brd(1,1,0, 2,2,0, 0,0,0), P1T, "e");
    add(1'b0, BC,   1'b0, 1, brd(1,1,1, 2,2,0, 0,0,0), P1W, "c_win");
    add(1'b0, BF,   1'b0, 1, brd(1,1,1, 2,2,0, 0,0,0), P1W, "f_frozen");
    // Game B: computer opponent, priorities, then computer wins.
    add(1'b1, NONE, 1'b0, 1, brd(0,0,0, 0,0,0, 0,0,0), P1T, "reset_B");
    add(1'b0, BA,   1'b0, 1, brd(1,0,0, 0,0,0, 0,0,0), P2T, "b_a");
    add(1'b0, NONE, 1'b1, 1, brd(1,0,0, 0,2,0, 0,0,0), P1T, "comp_centre");
    add(1'b0, BB,   1'b0, 1, brd(1,1,0, 0,2,0, 0,0,0), P2T, "b_b");
    add(1'b0, NONE, 1'b1, 1, brd(1,1,2, 0,2,0, 0,0,0), P1T, "comp_block");
    add(1'b0, NONE, 1'b1, 1, brd(1,1,2, 0,2,0, 0,0,0), P1T, "comp_on_p1_turn");
    add(1'b0, BA|BD, 1'b0, 1, brd(1,1,2, 0,2,0, 0,0,0), P1T, "a_d_occupied_prio");
    add(1'b0, BD|BF, 1'b0, 1, brd(1,1,2, 1,2,0, 0,0,0), P2T, "d_f_prio");
    add(1'b0, BF,   1'b1, 1, brd(1,1,2, 1,2,2, 0,0,0), P1T, "f_beats_comp");
    add(1'b0, BH,   1'b0, 1, brd(1,1,2, 1,2,2, 0,1,0), P2T, "b_h");
    add(1'b0, NONE, 1'b1, 1, brd(1,1,2, 1,2,2, 0,1,2), P2W, "comp_completes");
    add(1'b0, BG,   1'b0, 1, brd(1,1,2, 1,2,2, 0,1,2), P2W, "g_frozen");
    // Game C: draw on a full grid.
    add(1'b1, BA,   1'b0, 1, brd(1,0,0, 0,0,0, 0,0,0), P2T, "c_a");
    add(1'b0, BB,   1'b0, 1, brd(1,2,0, 0,0,0, 0,0,0), P1T, "c_b");
    add(1'b0, BC,   1'b0, 1, brd(1,2,1, 0,0,0, 0,0,0), P2T, "c_c");
    add(1'b0, BE,   1'b0, 1, brd(1,2,1, 0,2,0, 0,0,0), P1T, "c_e");
    add(1'b0, BD,   1'b0, 1, brd(1,2,1, 1,2,0, 0,0,0), P2T, "c_d");
    add(1'b0, BF,   1'b0, 1, brd(1,2,1, 1,2,2, 0,0,0), P1T, "c_f");
    add(1'b0, BH,   1'b0, 1, brd(1,2,1, 1,2,2, 0,1,0), P2T, "c_h");
    add(1'b0, BG,   1'b0, 1, brd(1,2,1, 1,2,2, 2,1,0), P1T, "c_g");
    add(1'b0, BI,   1'b0, 1, brd(1,2,1, 1,2,2, 2,1,1), FULL, "c_i_full");
    add(1'b0, BE,   1'b0, 1, brd(1,2,1, 1,2,2, 2,1,1), FULL, "full_frozen");

    repeat (2) @(negedge clk);
    reset = 1'b0;

    foreach (tbl[k]) begin
      if (tbl[k].rst_before) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      drive(tbl[k].btn, tbl[k].comp);
      expect_state(tbl[k].leds, tbl[k].flg, tbl[k].name);
      repeat (tbl[k].hold) @(negedge clk);
      drive(NONE, 1'b0);
      @(negedge clk);
      check_now();
    end

    // Async reset in the middle of a fresh game, between clock edges.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(BA, 1'b0);
    expect_state(brd(1,0,0, 0,0,0, 0,0,0), P2T, "mid_game_move");
    @(negedge clk);
    drive(NONE, 1'b0);
    @(negedge clk);
    check_now();
    #2 reset = 1'b1;
    expect_state(brd(0,0,0, 0,0,0, 0,0,0), P1T, "async_reset_now");
    #1 check_now();
    @(negedge clk);
    reset = 1'b0;
    expect_state(brd(0,0,0, 0,0,0, 0,0,0), P1T, "after_release");
    @(negedge clk);
    check_now();
    drive(BE, 1'b0);
    expect_state(brd(0,0,0, 0,1,0, 0,0,0), P2T, "play_after_reset");
    @(negedge clk);
    drive(NONE, 1'b0);
    @(negedge clk);
    check_now();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
